// File: rtl/tree_vote_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// tree_vote_pkg
// Shared types and constants for the tree_vote_scheduler block:
//   - default ensemble geometry (N_FEAT / N_CLASSES / N_TREES)
//   - clog2 helper and the derived widths TW / CW / VW
//   - FSM state enum
// Optional feature macro used elsewhere in this slice: TREE_VOTE_PIPE_EN.
// -----------------------------------------------------------------------------
package tree_vote_pkg;

    localparam int N_FEAT    = 51;
    localparam int N_CLASSES = 6;
    localparam int N_TREES   = 8;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    localparam int TW = clog2(N_TREES);      // tree index width
    localparam int CW = clog2(N_CLASSES);    // class index width
    localparam int VW = clog2(N_TREES + 1);  // vote counter width, holds 0..N_TREES

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        DECIDE = 2'd2,
        OUT    = 2'd3
    } state_e;

endpackage

// File: rtl/tree_vote_scheduler_if.sv
// -----------------------------------------------------------------------------
// tree_vote_scheduler_if
// Bundles the feature-input handshake, the tree-bank select/response pair and
// the result handshake of tree_vote_scheduler.
//   slave  : view of the scheduler itself
//   master : view of the surroundings (feature source, tree bank, consumer)
// Signals:
//   in_valid/in_ready/in_feat      feature vector handshake
//   tree_feat/tree_sel/tree_vote   tree bank drive and response
//   out_valid/out_ready            result handshake
//   out_class/out_votes/out_tie    result payload
//   busy                           scheduler not idle
// -----------------------------------------------------------------------------
interface tree_vote_scheduler_if;
    import tree_vote_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [N_FEAT-1:0]    in_feat;
    logic [N_FEAT-1:0]    tree_feat;
    logic [TW-1:0]        tree_sel;
    logic [N_CLASSES-1:0] tree_vote;
    logic                 out_valid;
    logic                 out_ready;
    logic [CW-1:0]        out_class;
    logic [VW-1:0]        out_votes;
    logic                 out_tie;
    logic                 busy;

    modport slave (
        input  in_valid, in_feat, tree_vote, out_ready,
        output in_ready, tree_feat, tree_sel, out_valid,
               out_class, out_votes, out_tie, busy
    );

    modport master (
        output in_valid, in_feat, tree_vote, out_ready,
        input  in_ready, tree_feat, tree_sel, out_valid,
               out_class, out_votes, out_tie, busy
    );

endinterface

// File: rtl/tree_vote_scheduler_vote_argmax.sv
// -----------------------------------------------------------------------------
// vote_argmax
// Purely combinational argmax over the per-class vote counters.
// Ports:
//   i_cnt  in   N_CLASSES x VW  per-class vote counts
//   o_idx  out  CW              index of the largest count (lowest index on ties)
//   o_max  out  VW              largest count
//   o_tie  out  1               another class shares the largest count
// -----------------------------------------------------------------------------
module vote_argmax
    import tree_vote_pkg::*;
(
    input  logic [N_CLASSES-1:0][VW-1:0] i_cnt,
    output logic [CW-1:0]                o_idx,
    output logic [VW-1:0]                o_max,
    output logic                         o_tie
);

    logic [CW-1:0] w_idx;
    logic [VW-1:0] w_max;
    logic          w_tie;
    logic          w_seen;

    // NOTE: combinational logic uses blocking assignments, and every variable
    // gets a default first so no latch can be inferred.
    always_comb begin
        w_idx  = '0;
        w_max  = i_cnt[0];
        w_tie  = 1'b0;
        w_seen = 1'b0;
        // Strict '>' keeps the earliest class when counts are equal.
        for (int k = 1; k < N_CLASSES; k++) begin
            if (i_cnt[k] > w_max) begin
                w_max = i_cnt[k];
                w_idx = CW'(k);
            end
        end
        // A tie exists when a second class reaches the same maximum.
        for (int k = 0; k < N_CLASSES; k++) begin
            if (i_cnt[k] == w_max) begin
                if (w_seen) begin
                    w_tie = 1'b1;
                end
                w_seen = 1'b1;
            end
        end
    end

    assign o_idx = w_idx;
    assign o_max = w_max;
    assign o_tie = w_tie;

endmodule

// File: rtl/tree_vote_scheduler.sv
// -----------------------------------------------------------------------------
// tree_vote_scheduler
// Accepts one feature vector, walks the external tree bank through every tree
// index (one per cycle), accumulates per-class votes and returns the winning
// class, its vote count and a tie flag.
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    tree_vote_scheduler_if.slave (feature handshake, tree bank drive,
//          result handshake, busy)
// Configuration:
//   TREE_VOTE_PIPE_EN  when defined, tree_vote is registered once before
//                      accumulation; EVAL then lasts N_TREES+1 cycles and the
//                      latency grows by one cycle. Results are unchanged.
// -----------------------------------------------------------------------------
module tree_vote_scheduler
    import tree_vote_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    tree_vote_scheduler_if.slave  bus
);

    localparam logic [TW-1:0] LAST_SEL = TW'(N_TREES - 1);

    state_e                        r_state;
    logic                          r_in_ready;
    logic                          r_busy;
    logic                          r_out_valid;
    logic [N_FEAT-1:0]             r_tree_feat;
    logic [TW-1:0]                 r_tree_sel;
    logic [CW-1:0]                 r_out_class;
    logic [VW-1:0]                 r_out_votes;
    logic                          r_out_tie;
    logic [N_CLASSES-1:0][VW-1:0]  r_cnt;

    logic [N_CLASSES-1:0]          w_acc_vote;
    logic                          w_acc_en;
    logic                          w_eval_done;
    logic [CW-1:0]                 w_idx;
    logic [VW-1:0]                 w_max;
    logic                          w_tie;

`ifdef TREE_VOTE_PIPE_EN
    logic [N_CLASSES-1:0] r_vote_q;
    logic                 r_first;  // first EVAL cycle: r_vote_q is stale
    logic                 r_last;   // last tree presented, its vote still in r_vote_q

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vote_q <= '0;
        end else begin
            r_vote_q <= bus.tree_vote;
        end
    end

    assign w_acc_vote  = r_vote_q;
    assign w_acc_en    = !r_first;
    assign w_eval_done = r_last;
`else
    assign w_acc_vote  = bus.tree_vote;
    assign w_acc_en    = 1'b1;
    assign w_eval_done = (r_tree_sel == LAST_SEL);
`endif

    vote_argmax u_argmax (
        .i_cnt (r_cnt),
        .o_idx (w_idx),
        .o_max (w_max),
        .o_tie (w_tie)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_tree_feat <= '0;
            r_tree_sel  <= '0;
            r_out_class <= '0;
            r_out_votes <= '0;
            r_out_tie   <= 1'b0;
            // NOTE: the counters are a handful of flops, not a RAM, so they are
            // reset along with the rest of the state.
            r_cnt       <= '0;
`ifdef TREE_VOTE_PIPE_EN
            r_first     <= 1'b0;
            r_last      <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_tree_feat <= bus.in_feat;
                        r_tree_sel  <= '0;
                        r_cnt       <= '0;
                        r_in_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= EVAL;
`ifdef TREE_VOTE_PIPE_EN
                        r_first     <= 1'b1;
                        r_last      <= 1'b0;
`endif
                    end
                end

                EVAL: begin
                    if (w_acc_en) begin
                        for (int k = 0; k < N_CLASSES; k++) begin
                            r_cnt[k] <= r_cnt[k] + VW'(w_acc_vote[k]);
                        end
                    end
                    if (w_eval_done) begin
                        r_state <= DECIDE;
                    end else if (r_tree_sel != LAST_SEL) begin
                        r_tree_sel <= r_tree_sel + TW'(1);
                    end
`ifdef TREE_VOTE_PIPE_EN
                    r_first <= 1'b0;
                    // Hold the last index one extra cycle so its registered
                    // vote gets consumed.
                    if (r_tree_sel == LAST_SEL) begin
                        r_last <= 1'b1;
                    end
`endif
                end

                DECIDE: begin
                    r_out_class <= w_idx;
                    r_out_votes <= w_max;
                    r_out_tie   <= w_tie;
                    r_out_valid <= 1'b1;
                    r_state     <= OUT;
                end

                OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.busy      = r_busy;
    assign bus.tree_feat = r_tree_feat;
    assign bus.tree_sel  = r_tree_sel;
    assign bus.out_valid = r_out_valid;
    assign bus.out_class = r_out_class;
    assign bus.out_votes = r_out_votes;
    assign bus.out_tie   = r_out_tie;

endmodule

// File: tb/tb_tree_vote_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tree_vote_scheduler
// Self-checking bench for tree_vote_scheduler. The tree bank is modelled here
// either as a per-tree vote table or as a hash of the feature vector; expected
// results come from a counting/argmax reference computed over the vector the
// bench sent.
// -----------------------------------------------------------------------------
module tb_tree_vote_scheduler;
    import tree_vote_pkg::*;

`ifdef TREE_VOTE_PIPE_EN
    localparam int EXP_LAT = N_TREES + 2;
`else
    localparam int EXP_LAT = N_TREES + 1;
`endif

    logic clk;
    logic rst_n;

    tree_vote_scheduler_if tb_if ();

    tree_vote_scheduler u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Tree bank model: mode 0 = table indexed by tree, mode 1 = feature hash.
    int                   bank_mode;
    logic [N_CLASSES-1:0] tbl [N_TREES];

    function automatic logic [N_CLASSES-1:0] hash_vote(input logic [N_FEAT-1:0] f, input int t);
        logic [N_CLASSES-1:0] v;
        for (int k = 0; k < N_CLASSES; k++) begin
            v[k] = f[(t * N_CLASSES + k) % N_FEAT] ^ f[(t * 7 + k * 3 + 5) % N_FEAT];
        end
        return v;
    endfunction

    always_comb begin
        if (bank_mode == 0) begin
            tb_if.tree_vote = tbl[tb_if.tree_sel];
        end else begin
            tb_if.tree_vote = hash_vote(tb_if.tree_feat, int'(tb_if.tree_sel));
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tbl(input logic [N_CLASSES-1:0] lo, input logic [N_CLASSES-1:0] hi, input int split);
        bank_mode = 0;
        for (int t = 0; t < N_TREES; t++) begin
            tbl[t] = (t < split) ? lo : hi;
        end
    endtask

    // Reference: count each class's votes over all trees, pick the lowest
    // index holding the maximum, flag a tie if the maximum occurs twice.
    task automatic model(input logic [N_FEAT-1:0] f, output int e_cls, output int e_votes, output int e_tie);
        int cnt [N_CLASSES];
        logic [N_CLASSES-1:0] v;
        int n_max;
        for (int k = 0; k < N_CLASSES; k++) cnt[k] = 0;
        for (int t = 0; t < N_TREES; t++) begin
            v = (bank_mode == 0) ? tbl[t] : hash_vote(f, t);
            for (int k = 0; k < N_CLASSES; k++) cnt[k] += int'(v[k]);
        end
        e_cls = 0;
        for (int k = 1; k < N_CLASSES; k++) if (cnt[k] > cnt[e_cls]) e_cls = k;
        e_votes = cnt[e_cls];
        n_max = 0;
        for (int k = 0; k < N_CLASSES; k++) if (cnt[k] == e_votes) n_max++;
        e_tie = (n_max > 1) ? 1 : 0;
    endtask

    // Offer a vector for one edge; bench sits #1 after the accepting edge.
    task automatic accept(input string tag, input logic [N_FEAT-1:0] f);
        check({tag, "_in_ready_idle"}, 64'(tb_if.in_ready), 64'd1);
        tb_if.in_feat  = f;
        tb_if.in_valid = 1'b1;
        tick();
        tb_if.in_valid = 1'b0;
        check({tag, "_tree_feat"}, 64'(tb_if.tree_feat), 64'(f));
        check({tag, "_busy"}, 64'(tb_if.busy), 64'd1);
    endtask

    // Wait for the result, check it, hold it for 'stall' cycles, then complete
    // the output handshake.
    task automatic finish(input string tag, input logic [N_FEAT-1:0] f, input int stall);
        int lat;
        int e_cls, e_votes, e_tie;
        model(f, e_cls, e_votes, e_tie);
        lat = 0;
        tb_if.out_ready = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (tb_if.out_valid === 1'b1) begin
                lat = i;
                break;
            end
            check({tag, "_in_ready_busy"}, 64'(tb_if.in_ready), 64'd0);
        end
        check({tag, "_latency"}, 64'(lat), 64'(EXP_LAT));
        check({tag, "_class"}, 64'(tb_if.out_class), 64'(e_cls));
        check({tag, "_votes"}, 64'(tb_if.out_votes), 64'(e_votes));
        check({tag, "_tie"}, 64'(tb_if.out_tie), 64'(e_tie));
        for (int i = 0; i < stall; i++) begin
            tick();
            check({tag, "_hold_valid"}, 64'(tb_if.out_valid), 64'd1);
            check({tag, "_hold_class"}, 64'(tb_if.out_class), 64'(e_cls));
            check({tag, "_hold_votes"}, 64'(tb_if.out_votes), 64'(e_votes));
            check({tag, "_hold_tie"}, 64'(tb_if.out_tie), 64'(e_tie));
            check({tag, "_hold_in_ready"}, 64'(tb_if.in_ready), 64'd0);
        end
        tb_if.out_ready = 1'b1;
        tick();
        tb_if.out_ready = 1'b0;
        check({tag, "_valid_clr"}, 64'(tb_if.out_valid), 64'd0);
        check({tag, "_ready_back"}, 64'(tb_if.in_ready), 64'd1);
        check({tag, "_busy_clr"}, 64'(tb_if.busy), 64'd0);
        check({tag, "_feat_held"}, 64'(tb_if.tree_feat), 64'(f));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, 64'(tb_if.in_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(tb_if.out_valid), 64'd0);
        check({tag, "_busy"}, 64'(tb_if.busy), 64'd0);
        check({tag, "_tree_feat"}, 64'(tb_if.tree_feat), 64'd0);
        check({tag, "_tree_sel"}, 64'(tb_if.tree_sel), 64'd0);
        check({tag, "_out_class"}, 64'(tb_if.out_class), 64'd0);
        check({tag, "_out_votes"}, 64'(tb_if.out_votes), 64'd0);
        check({tag, "_out_tie"}, 64'(tb_if.out_tie), 64'd0);
    endtask

    initial begin
        logic [N_FEAT-1:0] f1;
        logic [N_FEAT-1:0] f2;
        int seen;

        bank_mode       = 0;
        for (int t = 0; t < N_TREES; t++) tbl[t] = '0;
        tb_if.in_valid  = 1'b0;
        tb_if.in_feat   = '0;
        tb_if.out_ready = 1'b0;
        rst_n           = 1'b0;
        #23;
        check_reset_state("rst");
        rst_n = 1'b1;
        tick();

        // Class 3 from trees 0-5, class 1 from trees 6-7.
        set_tbl(6'b001000, 6'b000010, 6);
        f1 = 51'h1_2345_6789_ABCD;
        accept("t1", f1);
        finish("t1", f1, 1);

        // Classes 2 and 4 with four trees each: lowest index wins, tie set.
        set_tbl(6'b000100, 6'b010000, 4);
        f1 = 51'h7_0F0F_0F0F_0F0F;
        accept("t2", f1);
        finish("t2", f1, 0);

        // No votes at all.
        set_tbl(6'b000000, 6'b000000, 4);
        f1 = 51'h0_0000_0000_0001;
        accept("t3", f1);
        finish("t3", f1, 0);

        // Every class voted by every tree.
        set_tbl(6'b111111, 6'b111111, 4);
        f1 = 51'h5_5555_5555_5555;
        accept("t4", f1);
        finish("t4", f1, 0);

        // Output stalled 5 cycles with a second vector offered throughout.
        set_tbl(6'b100000, 6'b000001, 5);
        f1 = 51'h3_AAAA_BBBB_CCCC;
        f2 = 51'h4_1111_2222_3333;
        tb_if.in_feat  = f1;
        tb_if.in_valid = 1'b1;
        tick();
        check("stall_accept", 64'(tb_if.tree_feat), 64'(f1));
        tb_if.in_feat = f2;
        finish("stall", f1, 5);
        // Still in IDLE with in_valid high: the second vector goes in next edge.
        tick();
        tb_if.in_valid = 1'b0;
        check("stall_second_accept", 64'(tb_if.tree_feat), 64'(f2));
        finish("stall2", f2, 0);

        // Reset while EVAL is presenting tree 4.
        set_tbl(6'b000010, 6'b000100, 3);
        f1 = 51'h2_DEAD_BEEF_0123;
        accept("rst_mid", f1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (tb_if.tree_sel == TW'(4)) begin
                seen = 1;
                break;
            end
            tick();
        end
        check("rst_mid_sel4", 64'(seen), 64'd1);
        rst_n = 1'b0;
        #2;
        check_reset_state("rst_mid_abort");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_mid_no_out", 64'(tb_if.out_valid), 64'd0);
        end
        rst_n = 1'b1;
        tick();
        check("rst_mid_after", 64'(tb_if.out_valid), 64'd0);
        f2 = 51'h6_0123_4567_89AB;
        accept("rst_next", f2);
        finish("rst_next", f2, 0);

        // Randomised vectors through the feature-hash bank.
        bank_mode = 1;
        for (int n = 0; n < 20; n++) begin
            f1 = N_FEAT'({$urandom(), $urandom()});
            accept("rnd", f1);
            finish("rnd", f1, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
